// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator: pixel enable, DrawX/DrawY, syncs, blank and DAC gating.
// Optional macro VGA_RGB_REG_EN registers the colour path and delays hs/vs/blank_n by one pixel.
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pixel_clk_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank_n,
    output logic       frame_start,
    output logic       vblank_start,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_x, r_y;
    logic             r_pix_en, r_hs, r_vs, r_blank, r_frame, r_vblank;

    logic       w_tick;
    logic [9:0] w_x_next, w_y_next;
    logic       w_hs_next, w_vs_next, w_blank_next;

    assign w_tick = (r_div == DIV_LAST);

    // NOTE: every signal assigned here gets a value on all paths, so no latch is inferred.
    always_comb begin
        w_x_next = (r_x == H_LAST) ? 10'd0 : r_x + 10'd1;
        w_y_next = r_y;
        if (r_x == H_LAST) begin
            w_y_next = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
        end
        w_hs_next    = ~((w_x_next >= HS_START) && (w_x_next < HS_END));
        w_vs_next    = ~((w_y_next >= VS_START) && (w_y_next < VS_END));
        w_blank_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);
    end

    // Syncs and blank are computed from the next counter values so they change
    // on the same edge as DrawX/DrawY.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_pix_en <= 1'b0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_blank  <= 1'b0;
            r_frame  <= 1'b0;
            r_vblank <= 1'b0;
        end else begin
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_pix_en <= w_tick;
            r_frame  <= w_tick && (w_x_next == 10'd0) && (w_y_next == 10'd0);
            r_vblank <= w_tick && (w_x_next == 10'd0) && (w_y_next == V_VIS);
            if (w_tick) begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_hs    <= w_hs_next;
                r_vs    <= w_vs_next;
                r_blank <= w_blank_next;
            end
        end
    end

    assign pixel_clk_en = r_pix_en;
    assign DrawX        = r_x;
    assign DrawY        = r_y;
    assign frame_start  = r_frame;
    assign vblank_start = r_vblank;

`ifdef VGA_RGB_REG_EN
    logic       r_hs_d, r_vs_d, r_blank_d;
    logic [7:0] r_red, r_green, r_blue;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hs_d    <= 1'b1;
            r_vs_d    <= 1'b1;
            r_blank_d <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
        end else if (w_tick) begin
            r_hs_d    <= r_hs;
            r_vs_d    <= r_vs;
            r_blank_d <= r_blank;
            r_red     <= r_blank ? Red_in   : 8'h00;
            r_green   <= r_blank ? Green_in : 8'h00;
            r_blue    <= r_blank ? Blue_in  : 8'h00;
        end
    end

    assign hs      = r_hs_d;
    assign vs      = r_vs_d;
    assign blank_n = r_blank_d;
    assign VGA_R   = r_red;
    assign VGA_G   = r_green;
    assign VGA_B   = r_blue;
`else
    assign hs      = r_hs;
    assign vs      = r_vs;
    assign blank_n = r_blank;
    assign VGA_R   = r_blank ? Red_in   : 8'h00;
    assign VGA_G   = r_blank ? Green_in : 8'h00;
    assign VGA_B   = r_blank ? Blue_in  : 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a shrunken-raster instance
// compared every Clk against a reference computed from elapsed cycles since reset release.
module tb_vga_timing_gen;

    typedef struct packed {
        int d;
        int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
    } cfg_t;

    localparam cfg_t CD = '{d:2, hv:640, hf:16, hsw:96, hb:48, vv:480, vf:10, vsw:2, vb:33};
    localparam cfg_t CS = '{d:3, hv:20, hf:3, hsw:5, hb:4, vv:12, vf:2, vsw:2, vb:3};

    logic       Clk, Reset_n;
    logic [7:0] red, green, blue;

    logic       en_d, hs_d, vs_d, bl_d, fs_d, vb_d;
    logic [9:0] x_d, y_d;
    logic [7:0] r_d, g_d, b_d;
    logic       en_s, hs_s, vs_s, bl_s, fs_s, vb_s;
    logic [9:0] x_s, y_s;
    logic [7:0] r_s, g_s, b_s;

    vga_timing_gen u_vga (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk_en(en_d), .DrawX(x_d), .DrawY(y_d),
        .hs(hs_d), .vs(vs_d), .blank_n(bl_d), .frame_start(fs_d), .vblank_start(vb_d),
        .Red_in(red), .Green_in(green), .Blue_in(blue),
        .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d)
    );

    vga_timing_gen #(
        .CLK_DIV(CS.d), .H_VISIBLE(CS.hv), .H_FRONT(CS.hf), .H_SYNC(CS.hsw), .H_BACK(CS.hb),
        .V_VISIBLE(CS.vv), .V_FRONT(CS.vf), .V_SYNC(CS.vsw), .V_BACK(CS.vb)
    ) u_vga_s (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk_en(en_s), .DrawX(x_s), .DrawY(y_s),
        .hs(hs_s), .vs(vs_s), .blank_n(bl_s), .frame_start(fs_s), .vblank_start(vb_s),
        .Red_in(red), .Green_in(green), .Blue_in(blue),
        .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [49:0] got, input logic [49:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // {hs, vs, blank_n} for absolute pixel index p since release; p<=0 is the reset state.
    function automatic logic [2:0] flags(cfg_t c, int p);
        int ht, vt, x, y;
        logic h, v, b;
        if (p <= 0) return 3'b110;
        ht = c.hv + c.hf + c.hsw + c.hb;
        vt = c.vv + c.vf + c.vsw + c.vb;
        x  = p % ht;
        y  = (p / ht) % vt;
        h  = !((x >= c.hv + c.hf) && (x < c.hv + c.hf + c.hsw));
        v  = !((y >= c.vv + c.vf) && (y < c.vv + c.vf + c.vsw));
        b  = (x < c.hv) && (y < c.vv);
        return {h, v, b};
    endfunction

    function automatic logic [49:0] model(cfg_t c, int n, logic [23:0] rgb, logic [23:0] rgb_reg);
        int ht, vt, p, x, y;
        logic en, fs, vbs;
        logic [9:0] xv, yv;
        logic [2:0] f;
        logic [23:0] vga;
        ht  = c.hv + c.hf + c.hsw + c.hb;
        vt  = c.vv + c.vf + c.vsw + c.vb;
        p   = n / c.d;
        en  = (n > 0) && (n % c.d == 0);
        x   = p % ht;
        y   = (p / ht) % vt;
        xv  = 10'(x);
        yv  = 10'(y);
        fs  = en && (x == 0) && (y == 0);
        vbs = en && (x == 0) && (y == c.vv);
`ifdef VGA_RGB_REG_EN
        f   = flags(c, p - 1);
        vga = rgb_reg;
`else
        f   = flags(c, p);
        vga = f[0] ? rgb : 24'h0;
`endif
        return {en, xv, yv, f, fs, vbs, vga};
    endfunction

    int          n;
    bit          in_reset, first_phase, fixed_rgb;
    logic [23:0] lat_d, lat_s;
    int          hs_low_cnt, hs_fall_x, fs_first, fs_second;
    logic        prev_hs;

    task automatic step();
        logic [23:0] rgb;
        @(negedge Clk);
        rgb = {red, green, blue};
        if (!in_reset) begin
            n++;
            if (n % CD.d == 0) lat_d = flags(CD, n / CD.d - 1) & 3'b001 ? rgb : 24'h0;
            if (n % CS.d == 0) lat_s = flags(CS, n / CS.d - 1) & 3'b001 ? rgb : 24'h0;
        end
        check($sformatf("dflt n=%0d", n),
              {en_d, x_d, y_d, hs_d, vs_d, bl_d, fs_d, vb_d, r_d, g_d, b_d},
              model(CD, n, rgb, lat_d));
        check($sformatf("small n=%0d", n),
              {en_s, x_s, y_s, hs_s, vs_s, bl_s, fs_s, vb_s, r_s, g_s, b_s},
              model(CS, n, rgb, lat_s));
        if (first_phase) begin
            if (n >= 1 && n <= 1600 && !hs_d) hs_low_cnt++;
            if (prev_hs && !hs_d && hs_fall_x < 0) hs_fall_x = int'(x_d);
            prev_hs = hs_d;
            if (fs_s) begin
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
        end
        if (fixed_rgb) {red, green, blue} = 24'hFFAA00;
        else {red, green, blue} = 24'($urandom);
    endtask

    // Reset asserted between edges; outputs must drop before any further Clk edge.
    task automatic async_reset(input int hold);
        #2 Reset_n = 1'b0;
        in_reset = 1'b1;
        n     = 0;
        lat_d = '0;
        lat_s = '0;
        #1;
        check("async_rst dflt", {en_d, x_d, y_d, hs_d, vs_d, bl_d, fs_d, vb_d, r_d, g_d, b_d},
              model(CD, 0, {red, green, blue}, 24'h0));
        check("async_rst small", {en_s, x_s, y_s, hs_s, vs_s, bl_s, fs_s, vb_s, r_s, g_s, b_s},
              model(CS, 0, {red, green, blue}, 24'h0));
        repeat (hold) step();
        Reset_n  = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        int hs_fall_exp;
        Reset_n     = 1'b0;
        in_reset    = 1'b1;
        n           = 0;
        lat_d       = '0;
        lat_s       = '0;
        fixed_rgb   = 1'b1;
        first_phase = 1'b0;
        {red, green, blue} = 24'hFFAA00;
        hs_low_cnt = 0;
        hs_fall_x  = -1;
        fs_first   = -1;
        fs_second  = -1;
        prev_hs    = 1'b1;

        repeat (3) step();
        Reset_n     = 1'b1;
        in_reset    = 1'b0;
        first_phase = 1'b1;
        repeat (4000) step();
        first_phase = 1'b0;

`ifdef VGA_RGB_REG_EN
        hs_fall_exp = CD.hv + CD.hf + 1;
`else
        hs_fall_exp = CD.hv + CD.hf;
`endif
        check("hs_low_clks", 50'(hs_low_cnt), 50'(CD.hsw * CD.d));
        check("hs_fall_x", 50'(hs_fall_x), 50'(hs_fall_exp));
        check("frame_period", 50'(fs_second - fs_first),
              50'(CS.d * (CS.hv + CS.hf + CS.hsw + CS.hb) * (CS.vv + CS.vf + CS.vsw + CS.vb)));

        fixed_rgb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(500, 3000)) step();
            async_reset($urandom_range(1, 4));
        end
        repeat (2000) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
